// File: rtl/timer_core_ndigit.sv
// Multi-digit cascaded timer core (NUM_DIGITS digits, radix DIGIT_MAX+1), up/down count, pause, end detect, wrap flag.
// Latency: count and all flags update one cycle after tick/run_en/clear is sampled; all outputs are registered.
// Backpressure: none; tick is a one-cycle enable, run_en=0 pauses. Optional AUTO_RELOAD_EN: reload preset instead of stopping at end_val.
module timer_core_ndigit #(
    parameter int NUM_DIGITS = 4,
    parameter int DIGIT_W    = 4,
    parameter int DIGIT_MAX  = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick,
    input  logic                          run_en,
    input  logic                          mode_down,
    input  logic                          clear,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] end_val,
    output logic [NUM_DIGITS*DIGIT_W-1:0] count,
    output logic                          running,
    output logic                          done,
    output logic                          wrap,
    output logic                          at_end
);

    localparam int CW = NUM_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] DMAX = DIGIT_W'(DIGIT_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic            dir_q, dir_d;
    logic            running_q, running_d;
    logic            done_q, done_d;
    logic            wrap_q, wrap_d;
    logic            at_end_q, at_end_d;

    logic [CW-1:0]      load_cl;
    logic [CW-1:0]      step_cnt;
    logic               step_wrap;
    logic               carry;
    logic [DIGIT_W-1:0] digit;

`ifdef AUTO_RELOAD_EN
    logic            reload_q, reload_d;
`endif

    // Any preset digit above the radix limit is forced to DIGIT_MAX
    function automatic logic [CW-1:0] clamp_digits(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[i*DIGIT_W +: DIGIT_W] > DMAX) begin
                r[i*DIGIT_W +: DIGIT_W] = DMAX;
            end
        end
        return r;
    endfunction

    assign load_cl = clamp_digits(load_val);

    // Ripple carry/borrow through the digits; carry out of the top digit means a full-range wrap
    always_comb begin
        step_cnt = count_q;
        carry    = 1'b1;
        digit    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = count_q[i*DIGIT_W +: DIGIT_W];
            if (carry) begin
                if (!dir_q) begin
                    if (digit == DMAX) begin
                        step_cnt[i*DIGIT_W +: DIGIT_W] = '0;
                    end else begin
                        step_cnt[i*DIGIT_W +: DIGIT_W] = digit + 1'b1;
                        carry = 1'b0;
                    end
                end else begin
                    if (digit == '0) begin
                        step_cnt[i*DIGIT_W +: DIGIT_W] = DMAX;
                    end else begin
                        step_cnt[i*DIGIT_W +: DIGIT_W] = digit - 1'b1;
                        carry = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    // Next-state and registered-output logic; clear overrides everything else
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
`ifdef AUTO_RELOAD_EN
        reload_d = 1'b0;
`endif
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_en) begin
                        count_d = load_cl;
                        dir_d   = mode_down;
                        if (load_cl == end_val) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
`ifdef AUTO_RELOAD_EN
                    // Reload cycle after end_val was shown: no step taken
                    if (reload_q) begin
                        count_d = load_cl;
                        if (!run_en) begin
                            state_d = PAUSE;
                        end
                    end else
`endif
                    if (!run_en) begin
                        state_d = PAUSE;
                    end else if (tick) begin
                        count_d = step_cnt;
                        wrap_d  = step_wrap;
                        if (step_cnt == end_val) begin
                            done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                            reload_d = 1'b1;
`else
                            state_d  = DONE;
`endif
                        end
                    end
                end
                PAUSE: begin
                    if (run_en) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        running_d = (state_d == RUN);
        at_end_d  = (state_d == DONE);
    end

    // State, count and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            count_q   <= '0;
            dir_q     <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            wrap_q    <= 1'b0;
            at_end_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            running_q <= running_d;
            done_q    <= done_d;
            wrap_q    <= wrap_d;
            at_end_q  <= at_end_d;
        end
    end

`ifdef AUTO_RELOAD_EN
    // Pending-reload flag, set in the cycle end_val is shown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= 1'b0;
        end else begin
            reload_q <= reload_d;
        end
    end
`endif

    assign count   = count_q;
    assign running = running_q;
    assign done    = done_q;
    assign wrap    = wrap_q;
    assign at_end  = at_end_q;

endmodule

// File: tb/tb_timer_core_ndigit.sv
// Directed bench for timer_core_ndigit with two BCD digits.
// Observed vector layout: {count[7:0], running, done, wrap, at_end}.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_timer_core_ndigit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       run_en;
    logic       mode_down;
    logic       clear;
    logic [7:0] load_val;
    logic [7:0] end_val;
    logic [7:0] count;
    logic       running;
    logic       done;
    logic       wrap;
    logic       at_end;

    int n_pass  = 0;
    int n_total = 0;
    logic [11:0] obs;

    always #5 clk = ~clk;

    timer_core_ndigit #(
        .NUM_DIGITS(2),
        .DIGIT_W   (4),
        .DIGIT_MAX (9)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .run_en   (run_en),
        .mode_down(mode_down),
        .clear    (clear),
        .load_val (load_val),
        .end_val  (end_val),
        .count    (count),
        .running  (running),
        .done     (done),
        .wrap     (wrap),
        .at_end   (at_end)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
        obs = {count, running, done, wrap, at_end};
    endtask

    // Return to IDLE via clear, then load a preset and enter RUN (or DONE)
    task automatic begin_run(input logic [7:0] lv, input logic [7:0] ev, input logic dn);
        tick = 1'b0; run_en = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0; load_val = lv; end_val = ev; mode_down = dn; run_en = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tick = 1'b0; run_en = 1'b0; mode_down = 1'b0; clear = 1'b0;
        load_val = 8'h00; end_val = 8'h00;
        cyc(); cyc();
        n_total++;
        if (obs !== 12'h000) $display("FAIL reset: got %h required %h", obs, 12'h000);
        else n_pass++;
        rst_n = 1'b1;
        cyc();
        n_total++;
        if (obs !== 12'h000) $display("FAIL idle_after_reset: got %h required %h", obs, 12'h000);
        else n_pass++;
    endtask

    task automatic test_up_count();
        int dcount;
        dcount = 0;
        begin_run(8'h00, 8'h12, 1'b0);
        n_total++;
        if (obs !== {8'h00, 4'b1000}) $display("FAIL up_load: got %h required %h", obs, {8'h00, 4'b1000});
        else n_pass++;
        for (int i = 1; i <= 12; i++) begin
            tick = 1'b1;
            cyc();
            if (done) dcount++;
            if (i == 9) begin
                n_total++;
                if (count !== 8'h09) $display("FAIL up_nine: got %h required %h", count, 8'h09);
                else n_pass++;
            end
            if (i == 10) begin
                n_total++;
                if (count !== 8'h10) $display("FAIL up_carry: got %h required %h", count, 8'h10);
                else n_pass++;
            end
        end
        n_total++;
        if (obs !== {8'h12, 4'b0101}) $display("FAIL up_done: got %h required %h", obs, {8'h12, 4'b0101});
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; run_en = i[0];
            cyc();
            if (done) dcount++;
        end
        tick = 1'b0;
        n_total++;
        if (obs !== {8'h12, 4'b0001}) $display("FAIL up_hold: got %h required %h", obs, {8'h12, 4'b0001});
        else n_pass++;
        n_total++;
        if (dcount !== 1) $display("FAIL up_done_count: got %0d required %0d", dcount, 1);
        else n_pass++;
    endtask

    task automatic test_down_count();
        begin_run(8'h10, 8'h05, 1'b1);
        mode_down = 1'b0;
        tick = 1'b1;
        cyc();
        n_total++;
        if (obs !== {8'h09, 4'b1000}) $display("FAIL down_borrow: got %h required %h", obs, {8'h09, 4'b1000});
        else n_pass++;
        cyc(); cyc(); cyc();
        n_total++;
        if (obs !== {8'h06, 4'b1000}) $display("FAIL down_six: got %h required %h", obs, {8'h06, 4'b1000});
        else n_pass++;
        cyc();
        tick = 1'b0;
        n_total++;
        if (obs !== {8'h05, 4'b0101}) $display("FAIL down_done: got %h required %h", obs, {8'h05, 4'b0101});
        else n_pass++;
    endtask

    task automatic test_wrap();
        begin_run(8'h98, 8'h50, 1'b0);
        tick = 1'b1;
        cyc();
        n_total++;
        if (obs !== {8'h99, 4'b1000}) $display("FAIL wrap_99: got %h required %h", obs, {8'h99, 4'b1000});
        else n_pass++;
        cyc();
        n_total++;
        if (obs !== {8'h00, 4'b1010}) $display("FAIL wrap_up: got %h required %h", obs, {8'h00, 4'b1010});
        else n_pass++;
        cyc();
        n_total++;
        if (obs !== {8'h01, 4'b1000}) $display("FAIL wrap_pulse_len: got %h required %h", obs, {8'h01, 4'b1000});
        else n_pass++;
        for (int i = 0; i < 49; i++) cyc();
        n_total++;
        if (obs !== {8'h50, 4'b0101}) $display("FAIL wrap_done: got %h required %h", obs, {8'h50, 4'b0101});
        else n_pass++;
        begin_run(8'h01, 8'h50, 1'b1);
        tick = 1'b1;
        cyc(); cyc();
        tick = 1'b0;
        n_total++;
        if (obs !== {8'h99, 4'b1010}) $display("FAIL wrap_down: got %h required %h", obs, {8'h99, 4'b1010});
        else n_pass++;
    endtask

    task automatic test_pause();
        begin_run(8'h30, 8'h99, 1'b0);
        tick = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        n_total++;
        if (obs !== {8'h34, 4'b1000}) $display("FAIL pause_pre: got %h required %h", obs, {8'h34, 4'b1000});
        else n_pass++;
        run_en = 1'b0; mode_down = 1'b1;
        cyc(); cyc(); cyc();
        n_total++;
        if (obs !== {8'h34, 4'b0000}) $display("FAIL pause_hold: got %h required %h", obs, {8'h34, 4'b0000});
        else n_pass++;
        tick = 1'b0; run_en = 1'b1;
        cyc();
        n_total++;
        if (obs !== {8'h34, 4'b1000}) $display("FAIL pause_resume: got %h required %h", obs, {8'h34, 4'b1000});
        else n_pass++;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        n_total++;
        if (obs !== {8'h35, 4'b1000}) $display("FAIL pause_step: got %h required %h", obs, {8'h35, 4'b1000});
        else n_pass++;
    endtask

    task automatic test_load_equal_end();
        tick = 1'b0; run_en = 1'b0; clear = 1'b1;
        cyc();
        clear = 1'b0; load_val = 8'h07; end_val = 8'h07; mode_down = 1'b0;
        run_en = 1'b1; tick = 1'b1;
        cyc();
        n_total++;
        if (obs !== {8'h07, 4'b0101}) $display("FAIL leq_done: got %h required %h", obs, {8'h07, 4'b0101});
        else n_pass++;
        cyc();
        n_total++;
        if (obs !== {8'h07, 4'b0001}) $display("FAIL leq_hold: got %h required %h", obs, {8'h07, 4'b0001});
        else n_pass++;
        tick = 1'b0; clear = 1'b1;
        cyc();
        n_total++;
        if (obs !== {8'h00, 4'b0000}) $display("FAIL clear_from_done: got %h required %h", obs, {8'h00, 4'b0000});
        else n_pass++;
        clear = 1'b0; load_val = 8'hAF; end_val = 8'h00;
        cyc();
        run_en = 1'b0;
        n_total++;
        if (obs !== {8'h99, 4'b1000}) $display("FAIL clamp: got %h required %h", obs, {8'h99, 4'b1000});
        else n_pass++;
    endtask

    task automatic test_clear();
        begin_run(8'h20, 8'h99, 1'b0);
        tick = 1'b1;
        cyc();
        n_total++;
        if (count !== 8'h21) $display("FAIL clear_pre: got %h required %h", count, 8'h21);
        else n_pass++;
        clear = 1'b1;
        cyc();
        n_total++;
        if (obs !== {8'h00, 4'b0000}) $display("FAIL clear_tick: got %h required %h", obs, {8'h00, 4'b0000});
        else n_pass++;
        clear = 1'b0; run_en = 1'b0;
        cyc();
        tick = 1'b0;
        n_total++;
        if (obs !== {8'h00, 4'b0000}) $display("FAIL clear_idle: got %h required %h", obs, {8'h00, 4'b0000});
        else n_pass++;
    endtask

    task automatic test_async_reset();
        begin_run(8'h40, 8'h99, 1'b0);
        tick = 1'b1;
        cyc(); cyc();
        tick = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        obs = {count, running, done, wrap, at_end};
        n_total++;
        if (obs !== 12'h000) $display("FAIL async_reset: got %h required %h", obs, 12'h000);
        else n_pass++;
        #3 rst_n = 1'b1;
        run_en = 1'b0;
        cyc();
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_auto_reload();
        begin_run(8'h03, 8'h00, 1'b1);
        tick = 1'b1;
        cyc(); cyc(); cyc();
        n_total++;
        if (obs !== {8'h00, 4'b1100}) $display("FAIL reload_done1: got %h required %h", obs, {8'h00, 4'b1100});
        else n_pass++;
        cyc();
        n_total++;
        if (obs !== {8'h03, 4'b1000}) $display("FAIL reload_value: got %h required %h", obs, {8'h03, 4'b1000});
        else n_pass++;
        cyc(); cyc(); cyc();
        tick = 1'b0;
        n_total++;
        if (obs !== {8'h00, 4'b1100}) $display("FAIL reload_done2: got %h required %h", obs, {8'h00, 4'b1100});
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_pause();
        test_clear();
        test_async_reset();
`ifdef AUTO_RELOAD_EN
        test_auto_reload();
`else
        test_up_count();
        test_down_count();
        test_wrap();
        test_load_equal_end();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
